// File: rtl/btpipe_pkg.sv
// Shared state encoding and default sizing for the BTPipe block-flow controller.
package btpipe_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StXfer   = 2'd1,
        StSettle = 2'd2
    } btpipe_state_e;

    localparam int unsigned DEF_BLOCK_WORDS = 256;
    localparam int unsigned DEF_CNT_W       = 10;
    localparam int unsigned DEF_IN_DEPTH    = 1024;
    localparam int unsigned DEF_SETTLE_CYC  = 4;

endpackage

// File: rtl/btpipe_dir_fsm.sv
// One transfer direction: IDLE/XFER/SETTLE FSM, word counter, settle timer, registered ready.
// Block counter and sticky error flag exist only with BTPIPE_BLOCK_CTRL_STATS_EN defined.
module btpipe_dir_fsm
    import btpipe_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        strobe_i,
    input  logic        xfer_i,
    input  logic        eligible_i,
    output logic        ready_o,
    output logic [31:0] blk_cnt_o,
    output logic        err_o
);
    localparam int unsigned WordW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned SetW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [WordW-1:0] LastWord   = WordW'(BLOCK_WORDS - 1);
    localparam logic [SetW-1:0]  LastSettle = SetW'(SETTLE_CYC - 1);

    btpipe_state_e    state_d, state_q;
    logic [WordW-1:0] word_d, word_q;
    logic [SetW-1:0]  settle_d, settle_q;
    logic             ready_d, ready_q;
    logic             init_q;
    logic             last_word;

    assign last_word = (word_q == LastWord);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                // A write/read coinciding with the strobe is not counted.
                if (strobe_i) begin
                    state_d = StXfer;
                    word_d  = '0;
                end
            end
            StXfer: begin
                if (xfer_i) begin
                    if (last_word) begin
                        state_d  = StSettle;
                        word_d   = '0;
                        settle_d = '0;
                    end else begin
                        word_d = word_q + WordW'(1);
                    end
                end
            end
            StSettle: begin
                if (settle_q == LastSettle) begin
                    state_d = StIdle;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // init_q holds ready low on the first edge after reset release.
        ready_d = init_q && (state_d == StIdle) && eligible_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            word_q   <= '0;
            settle_q <= '0;
            ready_q  <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
            init_q   <= 1'b1;
        end
    end

    assign ready_o = ready_q;

`ifdef BTPIPE_BLOCK_CTRL_STATS_EN
    logic [31:0] blk_cnt_d, blk_cnt_q;
    logic        err_d, err_q;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        err_d     = err_q;
        if ((state_q == StXfer) && xfer_i && last_word) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
        if ((xfer_i && (state_q != StXfer)) || (strobe_i && (state_q != StIdle))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
    assign err_o     = err_q;
`else
    assign blk_cnt_o = '0;
    assign err_o     = 1'b0;
`endif

endmodule

// File: rtl/btpipe_block_ctrl.sv
// BTPipe block-flow controller: FIFO-level eligibility plus one FSM per pipe direction.
// Statistics (block counters, error flags) are built only with BTPIPE_BLOCK_CTRL_STATS_EN.
module btpipe_block_ctrl
    import btpipe_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned IN_DEPTH    = DEF_IN_DEPTH,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic             okClk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [CNT_W-1:0] in_wr_cnt,
    input  logic             in_blockstrobe,
    input  logic             in_write,
    input  logic [CNT_W-1:0] out_rd_cnt,
    input  logic             out_blockstrobe,
    input  logic             out_read,
    output logic             in_ready,
    output logic             out_ready,
    output logic [31:0]      in_blk_cnt,
    output logic [31:0]      out_blk_cnt,
    output logic             err_in,
    output logic             err_out
);
    logic [CNT_W:0] in_free;
    logic           in_elig;
    logic           out_elig;

    // One extra bit so the free-space difference cannot wrap.
    assign in_free  = (CNT_W+1)'(IN_DEPTH) - {1'b0, in_wr_cnt};
    assign in_elig  = enable && (in_free >= (CNT_W+1)'(BLOCK_WORDS));
    assign out_elig = enable && ({1'b0, out_rd_cnt} >= (CNT_W+1)'(BLOCK_WORDS));

    btpipe_dir_fsm #(
        .BLOCK_WORDS(BLOCK_WORDS),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_in_fsm (
        .clk_i     (okClk),
        .rst_ni    (rstn),
        .strobe_i  (in_blockstrobe),
        .xfer_i    (in_write),
        .eligible_i(in_elig),
        .ready_o   (in_ready),
        .blk_cnt_o (in_blk_cnt),
        .err_o     (err_in)
    );

    btpipe_dir_fsm #(
        .BLOCK_WORDS(BLOCK_WORDS),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_out_fsm (
        .clk_i     (okClk),
        .rst_ni    (rstn),
        .strobe_i  (out_blockstrobe),
        .xfer_i    (out_read),
        .eligible_i(out_elig),
        .ready_o   (out_ready),
        .blk_cnt_o (out_blk_cnt),
        .err_o     (err_out)
    );

endmodule

// File: doc/btpipe_block_ctrl.md
BTPIPE_BLOCK_CTRL -- requirements
Module: btpipe_block_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 256: 32-bit words per BTPipe block.
REQ-002 SHALL have parameter CNT_W, default 10: width of the FIFO count inputs.
REQ-003 SHALL have parameter IN_DEPTH, default 1024: pipe-in FIFO depth in words.
REQ-004 SHALL have parameter SETTLE_CYC, default 4: post-block wait for FIFO count latency.
REQ-005 SHALL have port okClk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rstn, input, 1: reset; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1: permits new blocks.
REQ-008 SHALL have port in_wr_cnt, input, CNT_W: pipe-in FIFO write-side count.
REQ-009 SHALL have port in_blockstrobe, input, 1: ep_blockstrobe from okBTPipeIn.
REQ-010 SHALL have port in_write, input, 1: ep_write from okBTPipeIn.
REQ-011 SHALL have port out_rd_cnt, input, CNT_W: pipe-out FIFO read-side count.
REQ-012 SHALL have port out_blockstrobe, input, 1: ep_blockstrobe from okBTPipeOut.
REQ-013 SHALL have port out_read, input, 1: ep_read from okBTPipeOut.
REQ-014 SHALL have port in_ready, output, 1: ep_ready to okBTPipeIn.
REQ-015 SHALL have port out_ready, output, 1: ep_ready to okBTPipeOut.
REQ-016 SHALL have port in_blk_cnt, output, 32: completed pipe-in blocks.
REQ-017 SHALL have port out_blk_cnt, output, 32: completed pipe-out blocks.
REQ-018 SHALL have port err_in, output, 1: sticky pipe-in protocol error.
REQ-019 SHALL have port err_out, output, 1: sticky pipe-out protocol error.

Function
REQ-020 SHALL run one FSM per direction with states IDLE, XFER, SETTLE.
REQ-021 SHALL move IDLE->XFER on a blockstrobe, with the word counter cleared.
REQ-022 SHALL count in_write (resp. out_read) only in XFER; the word that brings the counter to BLOCK_WORDS moves XFER->SETTLE, increments the block count, and clears the counter.
REQ-023 SHALL hold SETTLE for exactly SETTLE_CYC cycles, then return to IDLE.
REQ-024 SHALL register in_ready; it is 1 only in IDLE with enable=1 and (IN_DEPTH - in_wr_cnt) >= BLOCK_WORDS, computed CNT_W+1 bits wide with no wrap.
REQ-025 SHALL register out_ready; it is 1 only in IDLE with enable=1 and out_rd_cnt >= BLOCK_WORDS.
REQ-026 SHALL drive ready to 0 on the cycle after the strobe and keep it 0 through XFER and SETTLE.
REQ-027 SHALL block new readiness when enable is deasserted, while letting an in-progress block complete normally.
REQ-028 SHALL set the error flag on a write/read in IDLE or SETTLE, or on a blockstrobe in XFER or SETTLE; the offending word is not counted and state is unchanged.
REQ-029 SHALL ignore a write/read in the same cycle as an IDLE blockstrobe, and SHALL set the error flag for it.
REQ-030 SHALL keep the two directions fully independent; both readies may be high simultaneously.
REQ-031 SHALL let block counters wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 SHALL on rstn=0 asynchronously force: FSMs to IDLE, word counters 0, in_ready=0, out_ready=0, in_blk_cnt=0, out_blk_cnt=0, err_in=0, err_out=0.
REQ-033 SHALL discard a partial block on reset mid-XFER, with no count increment.
REQ-034 SHALL assert ready no earlier than the second okClk edge after rstn rises.

Configuration
REQ-035 SHALL, with BTPIPE_BLOCK_CTRL_STATS_EN defined, implement block counters and error flags as specified.
REQ-036 SHALL, without BTPIPE_BLOCK_CTRL_STATS_EN, tie in_blk_cnt, out_blk_cnt, err_in and err_out to constant 0 with no flops inferred, leaving FSM and ready behaviour identical.

Structure
REQ-037 SHALL place the state enum (IDLE/XFER/SETTLE) and the default BLOCK_WORDS/CNT_W/IN_DEPTH/SETTLE_CYC constants in shared package btpipe_pkg.
REQ-038 SHALL implement the per-direction FSM, word counter, settle timer, block counter and error flag as sub-module btpipe_dir_fsm, instantiated twice; eligibility compares stay in the top level.

Verification
REQ-039 SHALL cover: in_wr_cnt=0, enable=1, strobe, 256 writes -> in_ready 0 from strobe+1, in_blk_cnt=1, in_ready back to 1 after 4 SETTLE cycles.
REQ-040 SHALL cover: in_wr_cnt=769 -> in_ready=0; in_wr_cnt=768 -> in_ready=1 one cycle later.
REQ-041 SHALL cover: out_rd_cnt=255 -> out_ready=0; 256 -> out_ready=1; full block of 256 reads -> out_blk_cnt=1.
REQ-042 SHALL cover: write in IDLE with no strobe -> err_in=1 and held until reset; strobe in XFER -> err_out=1 for the out path.
REQ-043 SHALL cover: rstn low after 100 of 256 writes -> all outputs 0 immediately; after release, a full block gives in_blk_cnt=1.
REQ-044 SHALL cover: enable dropped mid-XFER -> block completes, in_blk_cnt increments, in_ready stays 0 until enable=1.
